// File: rtl/sa_pkg.sv
// Shared definitions for the 4x4 systolic array feeder.
// Contents:
//   N            array dimension
//   STREAM_BEATS number of skewed beats per tile (2*N-1)
//   BEAT_W       width of the beat counter
//   state_t      feeder FSM state encoding
//   elem_idx()   bit offset of tile element [r][c] in a row-major packed tile
package sa_pkg;

    localparam int N            = 4;
    localparam int STREAM_BEATS = 2 * N - 1;
    localparam int BEAT_W       = $clog2(STREAM_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int elem_idx(input int r, input int c, input int bw);
        return (4 * r + c) * bw;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One output lane of the skewed feeder.
// Row mode (COL_MODE=0): emits tile[LANE][beat-LANE] (A row, west side).
// Column mode (COL_MODE=1): emits tile[beat-LANE][LANE] (B column, north side).
// Outside the 4-beat window of this lane, or when inactive, the lane is 0.
// Ports:
//   tile_i    packed 4x4 tile, element [r][c] at (4*r+c)*BIT_WIDTH
//   beat_i    current beat index t
//   active_i  lane is streaming this beat
//   lane_o    selected element (combinational)
module skew_lane
    import sa_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int LANE      = 0,
    parameter bit COL_MODE  = 1'b0
) (
    input  logic [16*BIT_WIDTH-1:0] tile_i,
    input  logic [BEAT_W-1:0]       beat_i,
    input  logic                    active_i,
    output logic [BIT_WIDTH-1:0]    lane_o
);

    // The lane is delayed by LANE beats, so element k appears at beat LANE+k.
    always_comb begin
        lane_o = '0;
        for (int k = 0; k < N; k++) begin
            if (active_i && (int'(beat_i) == LANE + k)) begin
                if (COL_MODE) begin
                    lane_o = tile_i[elem_idx(k, LANE, BIT_WIDTH) +: BIT_WIDTH];
                end else begin
                    lane_o = tile_i[elem_idx(LANE, k, BIT_WIDTH) +: BIT_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder_4x4.sv
// Transmit side of the 4x4 systolic array's skewed north/west interface.
// Accepts an A and a B tile through valid/ready, streams them diagonally
// staggered over 7 beats, drains DRAIN_CYCLES zero cycles, then pulses done.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    tile handshake (ready only while idle)
//   a_tile, b_tile         A[i][k], B[k][j] packed at (4*r+c)*BIT_WIDTH
//   west_out0..3           skewed A rows, registered
//   north_out0..3          skewed B columns, registered
//   busy                   tile in flight (stream, drain, done)
//   done                   one-cycle pulse when the tile has been flushed
module systolic_feeder_4x4
    import sa_pkg::*;
#(
    parameter int BIT_WIDTH    = 16,
    parameter int FRAC_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*BIT_WIDTH-1:0] a_tile,
    input  logic [16*BIT_WIDTH-1:0] b_tile,
    output logic [BIT_WIDTH-1:0]    west_out0,
    output logic [BIT_WIDTH-1:0]    west_out1,
    output logic [BIT_WIDTH-1:0]    west_out2,
    output logic [BIT_WIDTH-1:0]    west_out3,
    output logic [BIT_WIDTH-1:0]    north_out0,
    output logic [BIT_WIDTH-1:0]    north_out1,
    output logic [BIT_WIDTH-1:0]    north_out2,
    output logic [BIT_WIDTH-1:0]    north_out3,
    output logic                    busy,
    output logic                    done
);

    // Data is passed through bit-exact; FRAC_WIDTH only has to be sane.
    if (FRAC_WIDTH < 0 || FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must lie in [0, BIT_WIDTH)");
    end

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [16*BIT_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                    accept;
    logic                    lane_active;
    logic [BIT_WIDTH-1:0]    west_d  [N];
    logic [BIT_WIDTH-1:0]    north_d [N];
    logic [BIT_WIDTH-1:0]    west_q  [N];
    logic [BIT_WIDTH-1:0]    north_q [N];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_STREAM;
                    beat_d  = '0;
                end
            end
            ST_STREAM: begin
                if (beat_q == BEAT_W'(STREAM_BEATS - 1)) begin
                    beat_d  = '0;
                    drain_d = '0;
                    state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // On the accept edge the lanes read the incoming tile directly so
        // beat 0 lands in the output registers on that same edge.
        a_d = accept ? a_tile : a_q;
        b_d = accept ? b_tile : b_q;
    end

    // Lanes look at next-state so outputs register the beat being entered.
    assign lane_active = (state_d == ST_STREAM);

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_lane #(
            .BIT_WIDTH(BIT_WIDTH),
            .LANE     (g),
            .COL_MODE (1'b0)
        ) u_west (
            .tile_i  (a_d),
            .beat_i  (beat_d),
            .active_i(lane_active),
            .lane_o  (west_d[g])
        );
        skew_lane #(
            .BIT_WIDTH(BIT_WIDTH),
            .LANE     (g),
            .COL_MODE (1'b1)
        ) u_north (
            .tile_i  (b_d),
            .beat_i  (beat_d),
            .active_i(lane_active),
            .lane_o  (north_d[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < N; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            for (int i = 0; i < N; i++) begin
                west_q[i]  <= west_d[i];
                north_q[i] <= north_d[i];
            end
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

    assign west_out0  = west_q[0];
    assign west_out1  = west_q[1];
    assign west_out2  = west_q[2];
    assign west_out3  = west_q[3];
    assign north_out0 = north_q[0];
    assign north_out1 = north_q[1];
    assign north_out2 = north_q[2];
    assign north_out3 = north_q[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Self-checking bench for systolic_feeder_4x4 with default parameters.
// The reference is the skew rule itself: at k clock edges after the accept
// edge, west_i = A[i][k-i] and north_j = B[k-j][j] inside the 4-beat window,
// with status derived from the tile's fixed lifetime of 12 cycles.
module tb_systolic_feeder_4x4;

    localparam int BW    = 16;
    localparam int DRAIN = 4;
    localparam int LAST  = 7 + DRAIN;   // edge index after accept where done shows

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [16*BW-1:0] a_tile, b_tile;
    logic [BW-1:0] w0, w1, w2, w3, n0, n1, n2, n3;
    logic          busy, done;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] ma [4][4];
    logic [BW-1:0] mb [4][4];

    always #5 clk = ~clk;

    systolic_feeder_4x4 #(.BIT_WIDTH(BW), .FRAC_WIDTH(8), .DRAIN_CYCLES(DRAIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_tile    (a_tile),
        .b_tile    (b_tile),
        .west_out0 (w0),
        .west_out1 (w1),
        .west_out2 (w2),
        .west_out3 (w3),
        .north_out0(n0),
        .north_out1(n1),
        .north_out2(n2),
        .north_out3(n3),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] get_w(input int i);
        case (i)
            0: return w0;
            1: return w1;
            2: return w2;
            default: return w3;
        endcase
    endfunction

    function automatic logic [BW-1:0] get_n(input int j);
        case (j)
            0: return n0;
            1: return n1;
            2: return n2;
            default: return n3;
        endcase
    endfunction

    function automatic logic [BW-1:0] exp_w(input int i, input int t);
        if (t - i >= 0 && t - i <= 3) return ma[i][t-i];
        return '0;
    endfunction

    function automatic logic [BW-1:0] exp_n(input int j, input int t);
        if (t - j >= 0 && t - j <= 3) return mb[t-j][j];
        return '0;
    endfunction

    task automatic pack_tiles();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_tile[(4*r+c)*BW +: BW] = ma[r][c];
                b_tile[(4*r+c)*BW +: BW] = mb[r][c];
            end
    endtask

    task automatic rand_tiles();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = BW'($urandom);
                mb[r][c] = BW'($urandom);
            end
    endtask

    task automatic check_beat(input string tag, input int k);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s west%0d k=%0d", tag, i, k), 32'(get_w(i)), 32'(exp_w(i, k)));
            chk($sformatf("%s north%0d k=%0d", tag, i, k), 32'(get_n(i)), 32'(exp_n(i, k)));
        end
    endtask

    task automatic check_status(input string tag, input int k);
        chk($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(k <= LAST));
        chk($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(k == LAST));
        chk($sformatf("%s ready k=%0d", tag, k), 32'(in_ready), 32'(k > LAST));
    endtask

    // Offer the current ma/mb while idle and follow the tile to idle again.
    task automatic run_tile(input string tag);
        chk({tag, " pre_ready"}, 32'(in_ready), 32'd1);
        pack_tiles();
        in_valid = 1'b1;
        for (int k = 0; k <= LAST + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                in_valid = 1'b0;
                a_tile = {8{$urandom}};
                b_tile = {8{$urandom}};
            end
            check_beat(tag, k);
            check_status(tag, k);
        end
    endtask

    logic cur_ready;
    int   n_acc, acc1, acc2, d1, d2;

    initial begin
        // Reset
        rst      = 1'b1;
        in_valid = 1'b0;
        a_tile   = '0;
        b_tile   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst ready", 32'(in_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst west%0d", i), 32'(get_w(i)), 32'd0);
            chk($sformatf("rst north%0d", i), 32'(get_n(i)), 32'd0);
        end

        // Golden skew pattern
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = BW'(16'h0100 * (c + 1));
                mb[r][c] = BW'(16'h0100 * (c + 1));
            end
        run_tile("golden");

        // Bit-exact extreme values
        rand_tiles();
        ma[0][0] = 16'hFF00;
        mb[3][3] = 16'h8000;
        run_tile("extreme");

        // Random tiles
        for (int n = 0; n < 3; n++) begin
            rand_tiles();
            run_tile($sformatf("rand%0d", n));
        end

        // in_valid held across two tiles
        rand_tiles();
        pack_tiles();
        in_valid = 1'b1;
        n_acc = 0; acc1 = -1; acc2 = -1; d1 = -1; d2 = -1;
        for (int e = 0; e < 25; e++) begin
            cur_ready = in_ready;
            @(posedge clk);
            #1;
            if (cur_ready && in_valid) begin
                if (n_acc == 0) begin
                    acc1 = e;
                    rand_tiles();
                    pack_tiles();
                end else begin
                    acc2 = e;
                end
                n_acc++;
            end
            if (done) begin
                if (d1 < 0) d1 = e - acc1 + 1;
                else        d2 = e - acc1 + 1;
            end
            if (acc2 >= 0) check_beat("b2b tile2", e - acc2);
            if (e == 24) in_valid = 1'b0;
        end
        chk("b2b accepts", 32'(n_acc), 32'd2);
        chk("b2b spacing", 32'(acc2 - acc1), 32'd13);
        chk("b2b done1", 32'(d1), 32'd12);
        chk("b2b done2", 32'(d2), 32'd25);
        @(posedge clk);
        #1;
        chk("b2b idle ready", 32'(in_ready), 32'd1);

        // Asynchronous reset during beat 3
        rand_tiles();
        pack_tiles();
        in_valid = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) in_valid = 1'b0;
            check_beat("abort", k);
        end
        rst = 1'b1;
        #1;
        chk("abort ready", 32'(in_ready), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort west%0d", i), 32'(get_w(i)), 32'd0);
            chk($sformatf("abort north%0d", i), 32'(get_n(i)), 32'd0);
        end
        rst = 1'b0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort quiet done e=%0d", e), 32'(done), 32'd0);
            chk($sformatf("abort quiet busy e=%0d", e), 32'(busy), 32'd0);
            chk($sformatf("abort quiet west3 e=%0d", e), 32'(w3), 32'd0);
        end
        rand_tiles();
        run_tile("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
